// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front end for a single-port, word-wide data memory with
// combinational read. Handles byte/half/word loads (sign or zero extended)
// and stores (sub-word stores via read-modify-write), one response per request.
//
// Request handshake: a request transfers on a rising clk edge where both
// req_valid and req_ready are high; req_ready is high only while idle, and
// req_* inputs are ignored at every other time. Responses are a one-cycle
// resp_valid pulse with no back-pressure; resp_rdata/resp_err hold until the
// next response.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  misaligned;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_addr_hi;

    // Address bits above the memory's word index are intentionally dropped (wrap).
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // Alignment check on the incoming request; size 3 is never legal.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension of the addressed memory word.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Merge sub-word store data into the current memory word, other lanes untouched.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'd0) begin
            case (lane_q)
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Request sequencer: all outputs registered, memory strobes issued from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            lane_q     <= 2'd0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_addr <= req_addr[ADDR_WIDTH+1:2];
                            // Full-word stores need no read, so write during ACCESS.
                            if (req_we && (req_size == 2'd2)) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (size_q == 2'd2) begin
                        mem_we     <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
